// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling,
// framing-error detection and break (held-low) suppression.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial_data,
    output logic [7:0] o_rx_parallel_data,
    output logic       o_rx_valid,
    output logic       o_rx_frame_err,
    output logic       o_rx_busy
);

    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state, state_n;
    logic        sync1, rx_s;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  data_n;
    logic        valid_n, ferr_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1              <= 1'b1;
            rx_s               <= 1'b1;
            state              <= IDLE;
            cnt                <= '0;
            idx                <= '0;
            shreg              <= '0;
            o_rx_parallel_data <= '0;
            o_rx_valid         <= 1'b0;
            o_rx_frame_err     <= 1'b0;
            o_rx_busy          <= 1'b0;
        end else begin
            sync1              <= i_rx_serial_data;
            rx_s               <= sync1;
            state              <= state_n;
            cnt                <= cnt_n;
            idx                <= idx_n;
            shreg              <= shreg_n;
            o_rx_parallel_data <= data_n;
            o_rx_valid         <= valid_n;
            o_rx_frame_err     <= ferr_n;
            o_rx_busy          <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = o_rx_parallel_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                cnt_n = cnt + 16'd1;
                // Decide on the edge where the count reaches mid-start-bit
                if (cnt + 16'd1 == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    shreg_n[idx] = rx_s;
                    cnt_n        = '0;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: prebuilt line waveform, frame-level model,
// per-cycle compare plus literal timing/data checks.
module tb_uart_rx;

    localparam int C = 16;
    localparam int H = (C - 1) / 2;
    localparam int N = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid, ferr, busy;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx_serial_data(rxd),
        .o_rx_parallel_data(data),
        .o_rx_valid(valid),
        .o_rx_frame_err(ferr),
        .o_rx_busy(busy)
    );

    always #5 clk = ~clk;

    // wl/wr: line and reset values sampled at edge k
    bit         wl [N];
    bit         wr [N];
    bit         rxs[N];
    bit         ev [N];
    bit         ee [N];
    bit         eb [N];
    logic [7:0] vb [N];
    logic [7:0] ed [N];
    bit         av [N];
    bit         ae [N];
    bit         ab [N];
    logic [7:0] ad [N];

    int p;
    int tests = 0;
    int fails = 0;
    int ecount = 0;
    bit run = 1'b0;
    int tA, tG, tE, t3c, tB, tR, rR, t7E, t15, t17, last;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string name, input int k, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s edge %0d: got %0h want %0h", name, k, act, expv);
        end
    endtask

    task automatic put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            wl[p] = v;
            wr[p] = 1'b0;
            p++;
        end
    endtask

    task automatic frame(input logic [7:0] b, input int per, input bit stopv);
        put(1'b0, per);
        for (int i = 0; i < 8; i++) put(b[i], per);
        put(stopv, per);
    endtask

    function automatic int first_rst(input int a, input int b);
        for (int i = a; i <= b; i++) if (wr[i]) return i;
        return -1;
    endfunction

    task automatic mark(input int a, input int b);
        for (int i = a; i <= b; i++) eb[i] = 1'b1;
    endtask

    // Frame-level model: hunt start, confirm at mid-start, sample every C
    task automatic build_model();
        bit s1, s2;
        int e, s, m, st, r, w;
        logic [7:0] b;
        s1 = 1'b1;
        s2 = 1'b1;
        rxs[0] = 1'b1;
        rxs[1] = 1'b1;
        for (int k = 1; k < N - 1; k++) begin
            s2 = wr[k] ? 1'b1 : s1;
            s1 = wr[k] ? 1'b1 : wl[k];
            rxs[k + 1] = s2;
        end
        e = 1;
        while (e < N) begin
            if (wr[e] || rxs[e]) begin
                e++;
                continue;
            end
            s = e;
            m = s + H;
            st = m + 9 * C;
            if (st >= N - 1) break;
            r = first_rst(s + 1, st);
            if (r >= 0 && r <= m) begin
                mark(s, r - 1);
                e = r;
                continue;
            end
            if (rxs[m]) begin
                mark(s, m - 1);
                e = m + 1;
                continue;
            end
            if (r >= 0) begin
                mark(s, r - 1);
                e = r;
                continue;
            end
            for (int k = 0; k < 8; k++) b[k] = rxs[m + (k + 1) * C];
            if (rxs[st]) begin
                ev[st] = 1'b1;
                vb[st] = b;
                mark(s, st - 1);
                e = st + 1;
            end else begin
                ee[st] = 1'b1;
                w = st + 1;
                while (w < N - 1 && !wr[w] && !rxs[w]) w++;
                mark(s, w - 1);
                e = wr[w] ? w : w + 1;
            end
        end
        ed[0] = 8'h00;
        for (int k = 1; k < N; k++)
            ed[k] = wr[k] ? 8'h00 : (ev[k] ? vb[k] : ed[k - 1]);
    endtask

    always @(negedge clk) begin
        if (run) begin
            av[ecount] = valid;
            ae[ecount] = ferr;
            ab[ecount] = busy;
            ad[ecount] = data;
            chk("valid", ecount, valid, ev[ecount]);
            chk("frame_err", ecount, ferr, ee[ecount]);
            chk("busy", ecount, busy, eb[ecount]);
            chk("data", ecount, data, ed[ecount]);
        end
    end

    function automatic int count_v(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += av[i];
        return n;
    endfunction

    function automatic int count_e(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += ae[i];
        return n;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) wl[i] = 1'b1;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            wr[p] = 1'b1;
            p++;
        end
        put(1'b1, 10);
        tA = p;
        frame(8'hA5, C, 1'b1);
        put(1'b1, 20);
        tG = p;
        put(1'b0, 4);
        put(1'b1, 30);
        tE = p;
        frame(8'h3C, C, 1'b0);
        put(1'b0, 40);
        put(1'b1, 10);
        t3c = p;
        frame(8'h3C, C, 1'b1);
        put(1'b1, 20);
        tB = p;
        frame(8'h00, C, 1'b1);
        frame(8'hFF, C, 1'b1);
        frame(8'h55, C, 1'b1);
        put(1'b1, 20);
        tR = p;
        put(1'b0, C);
        put(1'b1, C);
        put(1'b0, 3 * C);
        put(1'b0, 8);
        rR = p;
        wr[p] = 1'b1;
        p++;
        put(1'b1, 20);
        t7E = p;
        frame(8'h7E, C, 1'b1);
        put(1'b1, 20);
        t15 = p;
        frame(8'hC3, 15, 1'b1);
        put(1'b1, 30);
        t17 = p;
        frame(8'hC3, 17, 1'b1);
        put(1'b1, 30);
        last = p + 4;

        build_model();
        chk("model_a5_valid", tA + 153, ev[tA + 153], 1);
        chk("model_a5_data", tA + 153, vb[tA + 153], 8'hA5);
        chk("model_3c_err", tE + 153, ee[tE + 153], 1);
        chk("model_b2b_ff", tB + 313, vb[tB + 313], 8'hFF);

        rst = wr[1];
        rxd = wl[1];
        run = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            rst = wr[k + 1];
            rxd = wl[k + 1];
        end
        @(negedge clk);
        #1;
        run = 1'b0;

        chk("reset_data", 3, ad[3], 8'h00);
        chk("reset_busy", 3, ab[3], 0);
        chk("a5_valid", tA + 153, av[tA + 153], 1);
        chk("a5_data", tA + 153, ad[tA + 153], 8'hA5);
        chk("a5_valid_pre", tA + 152, av[tA + 152], 0);
        chk("a5_valid_post", tA + 154, av[tA + 154], 0);
        chk("a5_busy_t1", tA + 1, ab[tA + 1], 0);
        chk("a5_busy_t2", tA + 2, ab[tA + 2], 1);
        chk("a5_busy_t152", tA + 152, ab[tA + 152], 1);
        chk("a5_busy_t153", tA + 153, ab[tA + 153], 0);
        chk("glitch_busy", tG + 8, ab[tG + 8], 1);
        chk("glitch_idle", tG + 9, ab[tG + 9], 0);
        chk("glitch_pulses", tG, count_v(tG, tE - 1) + count_e(tG, tE - 1), 0);
        chk("err_pulse", tE + 153, ae[tE + 153], 1);
        chk("err_no_valid", tE + 153, av[tE + 153], 0);
        chk("err_data_hold", tE + 153, ad[tE + 153], 8'hA5);
        chk("err_wait_busy", tE + 190, ab[tE + 190], 1);
        chk("err_count", tE, count_e(tE, tB - 1), 1);
        chk("3c_valid", t3c + 153, av[t3c + 153], 1);
        chk("3c_data", t3c + 153, ad[t3c + 153], 8'h3C);
        chk("b2b_v0", tB + 153, av[tB + 153], 1);
        chk("b2b_d0", tB + 153, ad[tB + 153], 8'h00);
        chk("b2b_v1", tB + 313, av[tB + 313], 1);
        chk("b2b_d1", tB + 313, ad[tB + 313], 8'hFF);
        chk("b2b_v2", tB + 473, av[tB + 473], 1);
        chk("b2b_d2", tB + 473, ad[tB + 473], 8'h55);
        chk("b2b_count", tB, count_v(tB, tR - 1), 3);
        chk("rst_busy_pre", rR - 1, ab[rR - 1], 1);
        chk("rst_data", rR, ad[rR], 8'h00);
        chk("rst_busy", rR, ab[rR], 0);
        chk("rst_valid", rR, av[rR], 0);
        chk("rst_err", rR, ae[rR], 0);
        chk("rst_no_81", tR, count_v(tR, t7E + 152) + count_e(tR, t7E + 152), 0);
        chk("7e_valid", t7E + 153, av[t7E + 153], 1);
        chk("7e_data", t7E + 153, ad[t7E + 153], 8'h7E);
        chk("p15_valid", t15 + 153, av[t15 + 153], 1);
        chk("p15_data", t15 + 153, ad[t15 + 153], 8'hC3);
        chk("p17_valid", t17 + 153, av[t17 + 153], 1);
        chk("p17_data", t17 + 153, ad[t17 + 153], 8'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
